// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one operand bit per clock.
// A start/busy/done handshake wraps the conversion. Overflow flags operands >= 10^DIGITS.
module bin_bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    // Handshake: start is taken on a rising edge only while busy=0; done pulses
    // for one cycle with bcd/overflow updated on that same edge.
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [WORK_W-1:0]  work;
    logic [CNT_W-1:0]   cnt;
    logic               sticky;

    logic [BCD_W-1:0]   adj;
    logic [WORK_W-1:0]  shifted;
    logic               carry;

    always_comb begin
        adj = work[WORK_W-1 -: BCD_W];
        for (int k = 0; k < DIGITS; k++) begin
            if (adj[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        // The top digit's MSB leaves the register; it carries a full 10^DIGITS.
        carry   = adj[BCD_W-1];
        shifted = {adj[BCD_W-2:0], work[BIN_W-1:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            work     <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= {{BCD_W{1'b0}}, bin};
                        sticky <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    work   <= shifted;
                    cnt    <= cnt + 1'b1;
                    sticky <= sticky | carry;
                    if (cnt == LAST) begin
                        bcd      <= shifted[WORK_W-1 -: BCD_W];
                        overflow <= sticky | carry;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Bench for bin_bcd_seq: vector table, handshake corner sequences, random operands
// against an arithmetic reference, plus instances with other BIN_W/DIGITS settings.
module tb_bin_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    // default instance
    logic        start;
    logic [9:0]  bin;
    logic        busy, done, overflow;
    logic [15:0] bcd;

    // DIGITS=3 instance
    logic        start3;
    logic [9:0]  bin3;
    logic        busy3, done3, ov3;
    logic [11:0] bcd3;

    // BIN_W=16 instances sharing stimulus
    logic        start16;
    logic [15:0] bin16;
    logic        busy16a, done16a, ov16a, busy16b, done16b, ov16b;
    logic [19:0] bcd16a;
    logic [15:0] bcd16b;

    logic [16:0] exp_q[$];

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] bcd;
        logic        ov;
    } vec_t;

    vec_t vecs[8];

    bin_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow));

    bin_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ov3));

    bin_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16a (
        .clk(clk), .rst(rst), .start(start16), .bin(bin16),
        .busy(busy16a), .done(done16a), .bcd(bcd16a), .overflow(ov16a));

    bin_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut16b (
        .clk(clk), .rst(rst), .start(start16), .bin(bin16),
        .busy(busy16b), .done(done16b), .bcd(bcd16b), .overflow(ov16b));

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // reference: decimal digits of (v mod 10^digits) packed 4 bits each, overflow on top
    function automatic logic [32:0] model(input longint v, input int digits);
        longint lim = 1;
        longint rem;
        logic [31:0] r = '0;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        rem = v % lim;
        for (int d = 0; d < digits; d++) begin
            r[4*d +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return {(v >= lim), r};
    endfunction

    // driver: one conversion on the default instance, start held for one cycle
    task automatic run_main(input string name, input logic [9:0] v,
                            input logic [15:0] exp_bcd, input logic exp_ov);
        int n = 0;
        int bc;
        logic [16:0] e;
        exp_q.push_back({exp_ov, exp_bcd});
        bin = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        bin = 10'($urandom);
        bc = busy ? 1 : 0;
        while (!done && n < 40) begin
            tick();
            n++;
            if (!done && busy) bc++;
        end
        check({name, " latency"}, 64'(n), 64'd10);
        check({name, " busy cycles"}, 64'(bc), 64'd10);
        e = exp_q.pop_front();
        check({name, " result"}, {47'd0, overflow, bcd}, {47'd0, e});
    endtask

    task automatic run3(input logic [9:0] v, input logic [11:0] exp_bcd, input logic exp_ov);
        int n = 0;
        bin3 = v;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        while (!done3 && n < 40) begin
            tick();
            n++;
        end
        check("d3 latency", 64'(n), 64'd10);
        check("d3 result", {51'd0, ov3, bcd3}, {51'd0, exp_ov, exp_bcd});
    endtask

    task automatic run16(input logic [15:0] v, input logic [19:0] exp_a, input logic ov_a,
                         input logic [15:0] exp_b, input logic ov_b);
        int n = 0;
        bin16 = v;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        while (!done16a && n < 60) begin
            tick();
            n++;
        end
        check("w16 latency", 64'(n), 64'd16);
        check("w16 d4 done", {63'd0, done16b}, 64'd1);
        check("w16 d5 result", {43'd0, ov16a, bcd16a}, {43'd0, ov_a, exp_a});
        check("w16 d4 result", {47'd0, ov16b, bcd16b}, {47'd0, ov_b, exp_b});
    endtask

    initial begin
        int n;
        int dcount;
        int first_done;
        logic [32:0] m;
        logic [9:0] rv;

        vecs[0] = '{10'd0,    16'h0000, 1'b0};
        vecs[1] = '{10'd1,    16'h0001, 1'b0};
        vecs[2] = '{10'd9,    16'h0009, 1'b0};
        vecs[3] = '{10'd10,   16'h0010, 1'b0};
        vecs[4] = '{10'd100,  16'h0100, 1'b0};
        vecs[5] = '{10'd512,  16'h0512, 1'b0};
        vecs[6] = '{10'd999,  16'h0999, 1'b0};
        vecs[7] = '{10'd1023, 16'h1023, 1'b0};

        rst = 1'b1;
        start = 1'b0; bin = '0;
        start3 = 1'b0; bin3 = '0;
        start16 = 1'b0; bin16 = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset main", {60'd0, busy, done, overflow, |bcd}, 64'd0);
        check("reset others", {56'd0, busy3, done3, ov3, |bcd3, busy16a, done16a, ov16a, |bcd16a}, 64'd0);

        for (int i = 0; i < 8; i++)
            run_main($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ov);

        // back-to-back: second start lands in the first done cycle
        run_main("b2b 999", 10'd999, 16'h0999, 1'b0);
        first_done = cyc;
        run_main("b2b 1023", 10'd1023, 16'h1023, 1'b0);
        check("b2b spacing", 64'(cyc - first_done), 64'd11);
        tick();
        check("done one cycle", {63'd0, done}, 64'd0);

        // start while busy is ignored and not queued
        bin = 10'd500;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        repeat (3) begin tick(); n++; end
        bin = 10'd7;
        start = 1'b1;
        tick();
        n++;
        start = 1'b0;
        while (!done && n < 40) begin tick(); n++; end
        check("ignore latency", 64'(n), 64'd10);
        check("ignore result", {47'd0, overflow, bcd}, {47'd0, 1'b0, 16'h0500});
        dcount = 0;
        repeat (14) begin tick(); if (done) dcount++; end
        check("ignore no second done", 64'(dcount), 64'd0);

        // reset mid-conversion aborts without a done pulse
        bin = 10'd321;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort busy before rst", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort state", {47'd0, busy, overflow, bcd}, 64'd0);
        dcount = 0;
        repeat (15) begin
            if (done) dcount++;
            tick();
        end
        check("abort no done", 64'(dcount), 64'd0);
        run_main("after abort", 10'd42, 16'h0042, 1'b0);

        // other parameter sets
        run3(10'd1023, 12'h023, 1'b1);
        run3(10'd999, 12'h999, 1'b0);
        run16(16'd65535, 20'h65535, 1'b0, 16'h5535, 1'b1);
        run16(16'd10000, 20'h10000, 1'b0, 16'h0000, 1'b1);
        run16(16'd9999,  20'h09999, 1'b0, 16'h9999, 1'b0);

        // random operands against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            rv = 10'($urandom_range(0, 1023));
            m = model(longint'(rv), 4);
            run_main($sformatf("rand %0d", rv), rv, m[15:0], m[32]);
        end
        for (int i = 0; i < 50; i++) begin
            rv = 10'($urandom_range(0, 1023));
            m = model(longint'(rv), 3);
            run3(rv, m[11:0], m[32]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
